// File: rtl/sw_debounce_if.sv
// Switch-conditioner signal bundle: raw levels in, debounced word, edge pulses and sample tick out.
interface sw_debounce_if #(
    parameter int SW_WIDTH = 32
);
    logic [SW_WIDTH-1:0] i_sw_raw;
    logic [SW_WIDTH-1:0] o_io_sw;
    logic [SW_WIDTH-1:0] o_sw_rise;
    logic [SW_WIDTH-1:0] o_sw_fall;
    logic                o_tick;

    // master: the board side producing raw levels and consuming the conditioned word
    modport master (
        output i_sw_raw,
        input  o_io_sw,
        input  o_sw_rise,
        input  o_sw_fall,
        input  o_tick
    );

    modport slave (
        input  i_sw_raw,
        output o_io_sw,
        output o_sw_rise,
        output o_sw_fall,
        output o_tick
    );
endinterface

// File: rtl/sw_debounce.sv
// Per-bit switch synchroniser + tick-sampled debouncer with one-cycle rise/fall pulses.
// Latency 2 + (STABLE_TICKS-1)*TICK_DIV + 1 .. 2 + STABLE_TICKS*TICK_DIV cycles; no backpressure.
module sw_debounce #(
    parameter int SW_WIDTH     = 32,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 10
) (
    input  logic         i_clk,
    input  logic         i_rst,
    sw_debounce_if.slave bus
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = (STABLE_TICKS > 0) ? $clog2(STABLE_TICKS + 1) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

    logic [SW_WIDTH-1:0] s1;
    logic [SW_WIDTH-1:0] s2;
    logic [SW_WIDTH-1:0] io_sw;
    logic [SW_WIDTH-1:0] sw_rise;
    logic [SW_WIDTH-1:0] sw_fall;
    logic [SW_WIDTH-1:0] flip;
    logic [PW-1:0]       pre;
    logic                tick;
    logic [CW-1:0]       cnt [SW_WIDTH];

    assign tick = (pre == PRE_LAST);

    // A bit flips on the tick that completes STABLE_TICKS consecutive disagreeing samples.
    always_comb begin
        flip = '0;
        for (int i = 0; i < SW_WIDTH; i++) begin
            flip[i] = tick && (s2[i] != io_sw[i]) && (cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1      <= '0;
            s2      <= '0;
            pre     <= '0;
            io_sw   <= '0;
            sw_rise <= '0;
            sw_fall <= '0;
            for (int i = 0; i < SW_WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1      <= bus.i_sw_raw;
            s2      <= s1;
            pre     <= tick ? '0 : pre + 1'b1;
            io_sw   <= io_sw ^ flip;
            sw_rise <= flip & s2;
            sw_fall <= flip & ~s2;
            for (int i = 0; i < SW_WIDTH; i++) begin
                if (s2[i] == io_sw[i]) begin
                    cnt[i] <= '0;
                end else if (tick) begin
                    cnt[i] <= (cnt[i] == CNT_LAST) ? '0 : cnt[i] + 1'b1;
                end
            end
        end
    end

    assign bus.o_io_sw   = io_sw;
    assign bus.o_sw_rise = sw_rise;
    assign bus.o_sw_fall = sw_fall;
    assign bus.o_tick    = tick;
endmodule

// File: tb/tb_sw_debounce.sv
// Directed + random bench for sw_debounce, compared each cycle against a tick-counting reference model.
module tb_sw_debounce;
    localparam int W  = 32;
    localparam int TD = 4;
    localparam int ST = 3;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;

    sw_debounce_if #(.SW_WIDTH(W)) bus ();

    sw_debounce #(.SW_WIDTH(W), .TICK_DIV(TD), .STABLE_TICKS(ST)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus.slave)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;

    // Reference: raw seen two edges late; a bit follows it after ST ticks of continuous disagreement.
    logic [W-1:0] raw_d1, raw_d2, m_out, m_rise, m_fall;
    int           cyc;
    int           seen [W];
    logic         m_tick;
    assign m_tick = ((cyc % TD) == TD - 1);

    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            raw_d1 <= '0;
            raw_d2 <= '0;
            m_out  <= '0;
            m_rise <= '0;
            m_fall <= '0;
            cyc    <= 0;
            for (int i = 0; i < W; i++) seen[i] <= 0;
        end else begin
            raw_d1 <= bus.i_sw_raw;
            raw_d2 <= raw_d1;
            cyc    <= cyc + 1;
            m_rise <= '0;
            m_fall <= '0;
            for (int i = 0; i < W; i++) begin
                if (raw_d2[i] == m_out[i]) begin
                    seen[i] <= 0;
                end else if (m_tick) begin
                    if (seen[i] + 1 >= ST) begin
                        m_out[i]  <= raw_d2[i];
                        m_rise[i] <= raw_d2[i];
                        m_fall[i] <= ~raw_d2[i];
                        seen[i]   <= 0;
                    end else begin
                        seen[i] <= seen[i] + 1;
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        total++;
        assert (obs >= lo && obs <= hi) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Advance one clock and compare every output with the model away from the edge.
    task automatic cycle1();
        @(negedge i_clk);
        chk("io_sw", bus.o_io_sw, m_out);
        chk("rise", bus.o_sw_rise, m_rise);
        chk("fall", bus.o_sw_fall, m_fall);
        chk("tick", {31'b0, bus.o_tick}, {31'b0, m_tick});
        chk("rise_fall_excl", bus.o_sw_rise & bus.o_sw_fall, '0);
    endtask

    task automatic wait_flip(input logic [W-1:0] mask, output int lat);
        logic [W-1:0] prev;
        prev = bus.o_io_sw;
        lat  = -1;
        for (int n = 1; n <= 40; n++) begin
            cycle1();
            if (((bus.o_io_sw ^ prev) & mask) != '0) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        int first_tick;
        int pulses;
        int lat;
        int rise5;
        logic [W-1:0] raw;

        bus.i_sw_raw = '0;
        i_rst        = 1'b1;
        repeat (2) @(negedge i_clk);
        chk("reset_io", bus.o_io_sw, '0);
        chk("reset_pulses", bus.o_sw_rise | bus.o_sw_fall, '0);
        chk("reset_tick", {31'b0, bus.o_tick}, '0);
        i_rst = 1'b0;

        // 1: idle after reset
        first_tick = -1;
        pulses     = 0;
        for (int n = 1; n <= 100; n++) begin
            cycle1();
            if (bus.o_tick && first_tick < 0) first_tick = n;
            if ((bus.o_sw_rise | bus.o_sw_fall) != '0) pulses++;
        end
        chk_rng("first_tick", first_tick, 3, 3);
        chk_rng("idle_pulses", pulses, 0, 0);
        chk("idle_io", bus.o_io_sw, '0);

        // 2: single clean step
        bus.i_sw_raw = 32'h0000_0001;
        wait_flip(32'h0000_0001, lat);
        chk_rng("step_latency", lat, 11, 14);
        chk("step_io", bus.o_io_sw, 32'h0000_0001);
        chk("step_rise", bus.o_sw_rise, 32'h0000_0001);
        cycle1();
        chk("step_rise_gone", bus.o_sw_rise, '0);

        // 3: bounce on bit 5, random prescaler phase
        repeat ($urandom_range(0, 3)) cycle1();
        rise5 = 0;
        for (int ph = 0; ph < 6; ph++) begin
            raw          = bus.i_sw_raw;
            raw[5]       = (ph % 2 == 0);
            bus.i_sw_raw = raw;
            repeat (3) begin
                cycle1();
                if (bus.o_io_sw[5]) rise5 += 100;
                rise5 += int'(bus.o_sw_rise[5]);
            end
        end
        raw          = bus.i_sw_raw;
        raw[5]       = 1'b1;
        bus.i_sw_raw = raw;
        wait_flip(32'h0000_0020, lat);
        chk_rng("bounce_latency", lat, 11, 14);
        rise5 += int'(bus.o_sw_rise[5]);
        repeat (10) begin
            cycle1();
            rise5 += int'(bus.o_sw_rise[5]);
        end
        chk_rng("bounce_rise_count", rise5, 1, 1);

        // 4: sixteen bits rise and sixteen fall together
        bus.i_sw_raw = 32'h0000_FFFF;
        repeat (20) cycle1();
        chk("multi_pre", bus.o_io_sw, 32'h0000_FFFF);
        repeat ($urandom_range(0, 3)) cycle1();
        bus.i_sw_raw = 32'hFFFF_0000;
        wait_flip('1, lat);
        chk_rng("multi_latency", lat, 11, 14);
        chk("multi_io", bus.o_io_sw, 32'hFFFF_0000);
        chk("multi_rise", bus.o_sw_rise, 32'hFFFF_0000);
        chk("multi_fall", bus.o_sw_fall, 32'h0000_FFFF);

        // 5: reset in the middle of a debounce
        bus.i_sw_raw = '0;
        repeat (20) cycle1();
        bus.i_sw_raw = 32'h8000_0000;
        repeat (8) cycle1();
        i_rst = 1'b1;
        #1;
        chk("midrst_io", bus.o_io_sw, '0);
        chk("midrst_pulses", bus.o_sw_rise | bus.o_sw_fall, '0);
        chk("midrst_tick", {31'b0, bus.o_tick}, '0);
        @(negedge i_clk);
        i_rst = 1'b0;
        wait_flip(32'h8000_0000, lat);
        chk_rng("midrst_latency", lat, 11, 14);
        chk("midrst_rise", bus.o_sw_rise, 32'h8000_0000);
        repeat (5) cycle1();

        // 6: two-cycle glitch on bit 0
        pulses       = 0;
        bus.i_sw_raw = 32'h8000_0001;
        repeat (2) cycle1();
        bus.i_sw_raw = 32'h8000_0000;
        repeat (12) begin
            cycle1();
            if (bus.o_sw_rise[0] || bus.o_sw_fall[0] || bus.o_io_sw[0]) pulses++;
        end
        chk_rng("glitch_effects", pulses, 0, 0);
        chk("glitch_cnt0", W'(dut.cnt[0]), '0);

        // Random words with random hold lengths
        for (int k = 0; k < 30; k++) begin
            bus.i_sw_raw = $urandom;
            repeat ($urandom_range(1, 20)) cycle1();
        end
        repeat (20) cycle1();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
